// File: rtl/asteroid_scheduler_if.sv
// Scheduler <-> game-control / asteroid-array signal bundle.
// master = scheduler side, slave = game control and the asteroid units.
interface asteroid_scheduler_if #(
  parameter int N_SLOTS = 4
);
  logic               enable;
  logic [N_SLOTS-1:0] moving;
  logic [N_SLOTS-1:0] offscreen;
  logic [N_SLOTS-1:0] hit;
  logic [N_SLOTS-1:0] start;
  logic [3:0]         direct;
  logic [N_SLOTS-1:0] slot_reset;
  logic [3:0]         active_count;
  logic [15:0]        spawn_count;
  logic               busy;

  modport master (
    input  enable, moving, offscreen, hit,
    output start, direct, slot_reset, active_count, spawn_count, busy
  );

  modport slave (
    output enable, moving, offscreen, hit,
    input  start, direct, slot_reset, active_count, spawn_count, busy
  );
endinterface

// File: rtl/asteroid_scheduler.sv
// Spawn scheduler: every SPAWN_PERIOD cycles starts the lowest idle unit with an LFSR direction.
// All outputs registered (1-cycle response); start is held until moving, ack timeout or enable loss.
module asteroid_scheduler #(
  parameter int          N_SLOTS      = 4,
  parameter logic [23:0] SPAWN_PERIOD = 24'd12500000,
  parameter logic [23:0] ACK_TIMEOUT  = 24'd16777215,
  parameter logic [7:0]  LFSR_SEED    = 8'hA5
) (
  input logic                  clk,
  input logic                  reset,
  asteroid_scheduler_if.master sched_if
);
  localparam int SW = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_PICK, S_ISSUE} state_t;

  state_t             state_q;
  logic [23:0]        spawn_tmr_q;
  logic [23:0]        ack_tmr_q;
  logic [7:0]         lfsr_q, lfsr_d;
  logic [SW-1:0]      sel_q;
  logic [N_SLOTS-1:0] start_q;
  logic [3:0]         direct_q;
  logic [15:0]        spawn_cnt_q;
  logic               busy_q;
  logic [N_SLOTS-1:0] slot_reset_q, slot_reset_d;
  logic [N_SLOTS-1:0] pend_q, pend_d;
  logic [3:0]         active_cnt_q, active_cnt_d;
  logic [N_SLOTS-1:0] free_mask, pick_onehot;
  logic [SW-1:0]      pick_idx;
  logic               ack;

  function automatic logic [3:0] dir_code(input logic [2:0] idx);
    case (idx)
      3'd0:    dir_code = 4'b0010;
      3'd1:    dir_code = 4'b1010;
      3'd2:    dir_code = 4'b1000;
      3'd3:    dir_code = 4'b1001;
      3'd4:    dir_code = 4'b0001;
      3'd5:    dir_code = 4'b0101;
      3'd6:    dir_code = 4'b0100;
      default: dir_code = 4'b0110;
    endcase
  endfunction

  assign lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  assign ack    = sched_if.moving[sel_q];

  // Lowest free slot wins; slots awaiting retire cleanup are not free.
  always_comb begin
    free_mask   = ~sched_if.moving & ~pend_q;
    pick_idx    = '0;
    pick_onehot = '0;
    for (int i = N_SLOTS - 1; i >= 0; i--) begin
      if (free_mask[i]) begin
        pick_idx       = SW'(i);
        pick_onehot    = '0;
        pick_onehot[i] = 1'b1;
      end
    end
  end

  always_comb begin
    slot_reset_d = '0;
    pend_d       = '0;
    active_cnt_d = '0;
    for (int i = 0; i < N_SLOTS; i++) begin
      slot_reset_d[i] = sched_if.moving[i] & (sched_if.offscreen[i] | sched_if.hit[i])
                        & ~((state_q == S_ISSUE) && (sel_q == SW'(i))) & ~pend_q[i];
      pend_d[i]       = (pend_q[i] & sched_if.moving[i]) | slot_reset_d[i];
      active_cnt_d    = active_cnt_d + {3'b000, sched_if.moving[i]};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lfsr_q       <= LFSR_SEED;
      slot_reset_q <= '0;
      pend_q       <= '0;
      active_cnt_q <= '0;
    end else begin
      lfsr_q       <= lfsr_d;
      slot_reset_q <= slot_reset_d;
      pend_q       <= pend_d;
      active_cnt_q <= active_cnt_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      spawn_tmr_q <= '0;
      ack_tmr_q   <= '0;
      sel_q       <= '0;
      start_q     <= '0;
      direct_q    <= 4'b0010;
      spawn_cnt_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (sched_if.enable) begin
            state_q     <= S_WAIT;
            spawn_tmr_q <= SPAWN_PERIOD - 24'd1;
          end
        end
        S_WAIT: begin
          if (!sched_if.enable) begin
            state_q <= S_IDLE;
          end else if (spawn_tmr_q == 24'd0) begin
            state_q <= S_PICK;
            busy_q  <= 1'b1;
          end else begin
            spawn_tmr_q <= spawn_tmr_q - 24'd1;
          end
        end
        S_PICK: begin
          if (free_mask == '0) begin
            state_q     <= S_WAIT;
            spawn_tmr_q <= SPAWN_PERIOD - 24'd1;
            busy_q      <= 1'b0;
          end else begin
            state_q   <= S_ISSUE;
            sel_q     <= pick_idx;
            start_q   <= pick_onehot;
            direct_q  <= dir_code(lfsr_q[2:0]);
            ack_tmr_q <= ACK_TIMEOUT;
          end
        end
        S_ISSUE: begin
          // Timer hits zero on the cycle it counts down from 1, so start is high ACK_TIMEOUT cycles.
          if (ack) begin
            start_q     <= '0;
            busy_q      <= 1'b0;
            spawn_cnt_q <= spawn_cnt_q + 16'd1;
            spawn_tmr_q <= SPAWN_PERIOD - 24'd1;
            state_q     <= sched_if.enable ? S_WAIT : S_IDLE;
          end else if (!sched_if.enable) begin
            start_q <= '0;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else if (ack_tmr_q <= 24'd1) begin
            start_q     <= '0;
            busy_q      <= 1'b0;
            spawn_tmr_q <= SPAWN_PERIOD - 24'd1;
            state_q     <= S_WAIT;
          end else begin
            ack_tmr_q <= ack_tmr_q - 24'd1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign sched_if.start        = start_q;
  assign sched_if.direct       = direct_q;
  assign sched_if.slot_reset   = slot_reset_q;
  assign sched_if.active_count = active_cnt_q;
  assign sched_if.spawn_count  = spawn_cnt_q;
  assign sched_if.busy         = busy_q;
endmodule

// File: doc/asteroid_scheduler.md
# asteroid_scheduler

Spawn scheduler for a pool of `asteroid` units. It periodically picks the lowest-numbered idle unit and gives it a pseudo-random entry direction. It holds that unit's `start` until the unit reports `moving`, and retires moving units that leave the screen or are hit. It sits between the game-control FSM and the asteroid array; its outputs drive each unit's `start`, `direct` and per-unit reset (unit reset = global `reset` OR `slot_reset[i]`).

## Interface
- `N_SLOTS`, 4 — number of asteroid units managed (2..8)
- `SPAWN_PERIOD`, 24'd12500000 — clk cycles between spawn attempts (must be ≥2)
- `ACK_TIMEOUT`, 24'd16777215 — max cycles `start` is held waiting for `moving`
- `LFSR_SEED`, 8'hA5 — LFSR reset value, must be nonzero
- `clk` in 1 — system clock; the block's only clock
- `reset` in 1 — asynchronous, active-high; clears all state
- `enable` in 1 — spawning allowed (game running)
- `moving` in N_SLOTS — `moving` outputs of the units
- `offscreen` in N_SLOTS — unit i is outside the playfield (from bounds logic)
- `hit` in N_SLOTS — unit i was destroyed (from collision logic)
- `start` out N_SLOTS — one-hot start request to the selected unit
- `direct` out 4 — entry direction code, shared by all units
- `slot_reset` out N_SLOTS — one-cycle retire pulse per unit
- `active_count` out 4 — number of `moving` bits set, registered
- `spawn_count` out 16 — successful spawns since reset, wraps at 65535→0
- `busy` out 1 — high in PICK and ISSUE

## Operation
- FSM states: IDLE, WAIT, PICK, ISSUE.
- IDLE: if `enable`=1, go to WAIT and load the spawn timer with SPAWN_PERIOD-1.
- WAIT: the timer decrements each cycle. At 0, go to PICK. If `enable`=0, go to IDLE.
- PICK: the free mask is ~`moving` & ~`retire_pending`. Take the lowest set bit as `sel` and latch it.
  - If the mask is zero: skip this spawn, reload the timer, return to WAIT. `spawn_count` does not change.
  - Otherwise: latch `direct` from LFSR[2:0], go to ISSUE, and load the ack timer with ACK_TIMEOUT.
- Direction mapping from LFSR[2:0]: 0→0010, 1→1010, 2→1000, 3→1001, 4→0001, 5→0101, 6→0100, 7→0110. Only these eight codes are ever driven.
- ISSUE: `start[sel]`=1 and all other `start` bits are 0. `direct` is held stable.
  - `moving[sel]` rises: drop `start`, increment `spawn_count`, reload the spawn timer, go to WAIT.
  - Ack timer reaches 0: drop `start`, go to WAIT. No count.
  - `enable` falls: drop `start`, go to IDLE.
- LFSR: 8-bit Fibonacci, taps 8,6,5,4. Advances every cycle regardless of state.
- Retire logic runs in every state, independent of the FSM:
  - Condition for slot i: `moving[i]` & (`offscreen[i]` | `hit[i]`) & ~(state==ISSUE & sel==i).
  - Response: one-cycle `slot_reset[i]` pulse, and `retire_pending[i]` is set.
  - `retire_pending[i]` clears once `moving[i]`=0.
  - A pending slot receives no further pulse until it has cleared.
- Multiple slots may retire in the same cycle.
- `active_count` is the registered popcount of `moving`.

## Timing
- Reset values:
  - state IDLE; `start`=0; `direct`=4'b0010; `slot_reset`=0
  - `active_count`=0; `spawn_count`=0; `busy`=0
  - LFSR=`LFSR_SEED`; both timers 0; `retire_pending`=0
- All outputs are registered.
- First spawn attempt is SPAWN_PERIOD+1 cycles after `enable` is sampled high in IDLE: 1 cycle IDLE→WAIT, SPAWN_PERIOD cycles in WAIT, PICK on the next cycle. `start` rises the cycle after PICK.
- `start` falls in the cycle after `moving[sel]` is sampled high. `spawn_count` updates in that same cycle.
- `slot_reset[i]` is asserted the cycle after the retire condition is sampled. It is never asserted for more than one consecutive cycle.
- Simultaneous events:
  - `offscreen`/`hit` on `sel` during ISSUE is ignored.
  - Ack and timeout in the same cycle: ack wins.
  - Ack and `enable` fall in the same cycle: count the spawn, go to IDLE.
- Asynchronous `reset` mid-ISSUE: `start` drops immediately and no spawn is counted.

## Test plan
- SPAWN_PERIOD=10, N_SLOTS=4, all idle, `enable`=1 at cycle 0 → `start`=0001 at cycle 12. Ack after 3 cycles → `start` drops the next cycle, `spawn_count`=1.
- `moving`=0111 at PICK → `start`=1000. `moving`=1111 → no `start`, `spawn_count` unchanged, retry after SPAWN_PERIOD.
- ACK_TIMEOUT=5, never ack → `start` high exactly 5 cycles, then WAIT, `spawn_count`=0.
- `moving`=0011, `offscreen`=0010 held 4 cycles → exactly one `slot_reset`=0010 pulse. Lower `moving[1]` → slot 1 is selectable at the next PICK.
- Run 64 spawns → every `direct` value is one of the 8 legal codes, and the sequence matches the reference LFSR model from seed A5.
- Assert `reset` asynchronously mid-ISSUE → all outputs reach reset values before the next clk edge. Restart reproduces the same first `direct`.
